cve2_obi_arbiter: RTL and testbench
===================================

Name: cve2_obi_arbiter

Overview:
- Shares one OBI memory port between the core's instruction-fetch interface and its data (LSU) interface.
- Sits between cve2_top and a single-port system bus or scratchpad, for small X-HEEP-style configurations with one memory master per core.
- Arbitrates requests and tracks outstanding transactions in issue order.
- Routes each in-order response (rvalid/rdata/err) back to the requester that issued it.

Parameters:
- MaxOutstanding, 2, max in-flight granted-but-unanswered transactions (>=1); depth of the source-ID FIFO.
- DataPriority, 1'b0, 0 = round-robin between instr and data; 1 = data always wins when both request.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- instr_req_i  in  1  fetch request
- instr_gnt_o  out  1  fetch grant
- instr_rvalid_o  out  1  fetch response valid
- instr_addr_i  in  32  fetch address
- instr_rdata_o  out  32  fetch read data
- instr_err_o  out  1  fetch bus error
- data_req_i  in  1  LSU request
- data_gnt_o  out  1  LSU grant
- data_rvalid_o  out  1  LSU response valid
- data_we_i  in  1  LSU write enable
- data_be_i  in  4  LSU byte enables
- data_addr_i  in  32  LSU address
- data_wdata_i  in  32  LSU write data
- data_rdata_o  out  32  LSU read data
- data_err_o  out  1  LSU bus error
- mem_req_o  out  1  shared-port request
- mem_gnt_i  in  1  shared-port grant
- mem_rvalid_i  in  1  shared-port response valid
- mem_we_o  out  1  shared-port write enable
- mem_be_o  out  4  shared-port byte enables
- mem_addr_o  out  32  shared-port address
- mem_wdata_o  out  32  shared-port write data
- mem_rdata_i  in  32  shared-port read data
- mem_err_i  in  1  shared-port error
- resp_unexpected_o  out  1  one-cycle pulse: mem_rvalid_i arrived with no outstanding entry

Behaviour:
- Reset: all outputs 0. FIFO empty, FSM IDLE, round-robin pointer = data.
- FSM states:
  - IDLE, no request being presented.
  - HOLD, mem_req_o high and not yet granted; the selected source is frozen.
- IDLE:
  - If the FIFO is not full and any request is active, select a source and drive mem_req_o the same cycle (combinational path).
  - If mem_gnt_i=0, go to HOLD.
- HOLD:
  - Selection does not change, even if the other source's priority rises.
  - Return to IDLE on mem_gnt_i.
- Selection rules:
  - Fixed mode: data wins.
  - Round-robin mode: the source not granted last wins. The pointer updates only on an accepted handshake (mem_req_o & mem_gnt_i).
- Mux:
  - Instr selected: mem_we_o=0, mem_be_o=4'hF, mem_wdata_o=0, mem_addr_o=instr_addr_i.
  - Data selected: all data_* fields pass through.
  - mem_* payload = 0 when mem_req_o=0.
- Grant: <src>_gnt_o = mem_gnt_i & mem_req_o & selected==src. Zero-cycle, combinational.
- On each accepted handshake, push the source ID into the FIFO.
- Full FIFO (count==MaxOutstanding):
  - mem_req_o is held low.
  - A pop in the same cycle does NOT unblock the request; there is no rvalid->req combinational path.
  - Issue resumes the next cycle.
- Response:
  - mem_rvalid_i with the FIFO non-empty drives <head>_rvalid_o, rdata and err combinationally, then pops.
  - Non-head rvalid outputs = 0. rdata/err outputs = 0 when not valid.
- Same-cycle push and pop: both occur and count is unchanged.
- mem_rvalid_i with the FIFO empty: response dropped, resp_unexpected_o=1 for that cycle.
- Reset mid-operation: FIFO flushed and FSM returns to IDLE. Late responses from the slave after reset are reported via resp_unexpected_o.
- Ordering: responses are strictly in issue order. The slave must be in-order.

Decomposition:
- cve2_pkg gains:
  - arb_src_e (1-bit enum: ARB_SRC_INSTR=0, ARB_SRC_DATA=1).
  - arb_state_e (ARB_IDLE, ARB_HOLD).
- Sub-module cve2_arb_id_fifo:
  - Parameterized depth, 1-bit payload.
  - Ports: push/pop/full/empty/head, plus synchronous clear on rst_i.
  - Count width $clog2(MaxOutstanding+1).

Test Plan:
- Single fetch: instr_req_i=1, addr 0x0000_0180, mem_gnt_i=1 -> mem_be_o=4'hF, mem_we_o=0, instr_gnt_o=1 the same cycle. Later rvalid with rdata 0x0000_0013 -> instr_rvalid_o=1, instr_rdata_o=0x13, data_rvalid_o=0.
- Contention, round-robin: both req every cycle, mem_gnt_i=1, rvalid one cycle later -> grants alternate D,I,D,I starting with data after reset. Responses route accordingly.
- Fixed priority (DataPriority=1): both req for 4 cycles -> data_gnt_o=1 all 4 cycles, instr_gnt_o=0.
- Hold stability: instr requests alone, mem_gnt_i=0 for 3 cycles, data_req_i rises in cycle 2 -> mem_addr_o stays instr_addr_i until the grant. Data is granted next.
- Full FIFO, MaxOutstanding=2: two grants with no rvalid -> third request sees mem_req_o=0. rvalid in cycle N -> mem_req_o=1 in cycle N+1, not N.
- Reset and stray response: rst_i=1 for 1 cycle with 2 outstanding, then mem_rvalid_i=1 -> resp_unexpected_o=1, no <src>_rvalid_o.

Source files
------------

// File: rtl/cve2_obi_arbiter_pkg.sv
// Shared types and helpers for the instruction/data OBI port arbiter.
// Source IDs, FSM states and the source-selection rule live here.
package cve2_obi_arbiter_pkg;

  typedef enum logic {
    ARB_SRC_INSTR = 1'b0,
    ARB_SRC_DATA  = 1'b1
  } arb_src_e;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_HOLD = 1'b1
  } arb_state_e;

  localparam logic [3:0] INSTR_BE = 4'hF;

  // Contention is the only case where the mode matters; a lone requester always wins.
  function automatic arb_src_e arb_pick(input logic     instr_req,
                                        input logic     data_req,
                                        input logic     data_priority,
                                        input arb_src_e rr_next);
    arb_src_e pick;
    if (instr_req && data_req) begin
      pick = data_priority ? ARB_SRC_DATA : rr_next;
    end else if (data_req) begin
      pick = ARB_SRC_DATA;
    end else begin
      pick = ARB_SRC_INSTR;
    end
    return pick;
  endfunction

endpackage

// File: rtl/cve2_arb_id_fifo.sv
// In-order FIFO of source IDs for granted-but-unanswered transactions.
// Pushes while full and pops while empty are ignored.
module cve2_arb_id_fifo
  import cve2_obi_arbiter_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic     clk_i,
  input  logic     rst_i,
  input  logic     push_i,
  input  arb_src_e push_src_i,
  input  logic     pop_i,
  output arb_src_e head_o,
  output logic     full_o,
  output logic     empty_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Depth-1:0] mem_q;
  logic [PtrW-1:0]  wr_ptr_q;
  logic [PtrW-1:0]  rd_ptr_q;
  logic [CntW-1:0]  cnt_q;
  logic [CntW-1:0]  cnt_d;
  logic             push_s;
  logic             pop_s;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
    return (ptr == PtrW'(Depth - 1)) ? '0 : ptr + PtrW'(1);
  endfunction

  assign full_o  = (cnt_q == CntW'(Depth));
  assign empty_o = (cnt_q == '0);
  assign push_s  = push_i & ~full_o;
  assign pop_s   = pop_i & ~empty_o;
  assign head_o  = arb_src_e'(mem_q[rd_ptr_q]);

  always_comb begin
    cnt_d = cnt_q;
    case ({push_s, pop_s})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_s) begin
        mem_q[wr_ptr_q] <= push_src_i;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (pop_s) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/cve2_obi_arbiter.sv
// Shares one OBI port between instruction fetch and LSU, tracking outstanding
// transactions in issue order and routing in-order responses back to their issuer.
module cve2_obi_arbiter
  import cve2_obi_arbiter_pkg::*;
#(
  parameter int unsigned MaxOutstanding = 2,
  parameter bit          DataPriority   = 1'b0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        instr_req_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  input  logic [31:0] instr_addr_i,
  output logic [31:0] instr_rdata_o,
  output logic        instr_err_o,
  input  logic        data_req_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,
  output logic        mem_req_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_err_i,
  output logic        resp_unexpected_o
);

  arb_state_e state_q;
  arb_src_e   sel_q;
  arb_src_e   rr_q;
  arb_src_e   sel_s;
  arb_src_e   pick_s;
  arb_src_e   head_s;
  logic       req_s;
  logic       hs_s;
  logic       pop_s;
  logic       fifo_full_s;
  logic       fifo_empty_s;

  assign pick_s = arb_pick(instr_req_i, data_req_i, DataPriority, rr_q);

  // Fullness is a registered count, so a same-cycle pop never reopens issue.
  always_comb begin
    req_s = 1'b0;
    sel_s = pick_s;
    if (state_q == ARB_HOLD) begin
      req_s = 1'b1;
      sel_s = sel_q;
    end else begin
      req_s = (instr_req_i | data_req_i) & ~fifo_full_s;
      sel_s = pick_s;
    end
  end

  assign mem_req_o   = req_s & ~rst_i;
  assign hs_s        = mem_req_o & mem_gnt_i;
  assign instr_gnt_o = hs_s & (sel_s == ARB_SRC_INSTR);
  assign data_gnt_o  = hs_s & (sel_s == ARB_SRC_DATA);

  always_comb begin
    mem_we_o    = 1'b0;
    mem_be_o    = 4'h0;
    mem_addr_o  = 32'h0;
    mem_wdata_o = 32'h0;
    if (mem_req_o) begin
      case (sel_s)
        ARB_SRC_INSTR: begin
          mem_be_o   = INSTR_BE;
          mem_addr_o = instr_addr_i;
        end
        ARB_SRC_DATA: begin
          mem_we_o    = data_we_i;
          mem_be_o    = data_be_i;
          mem_addr_o  = data_addr_i;
          mem_wdata_o = data_wdata_i;
        end
        default: begin
          mem_be_o = 4'h0;
        end
      endcase
    end else begin
      mem_we_o = 1'b0;
    end
  end

  // The pending source is frozen while the slave stalls; the pointer moves only on a handshake.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ARB_IDLE;
      sel_q   <= ARB_SRC_INSTR;
      rr_q    <= ARB_SRC_DATA;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (req_s && !mem_gnt_i) begin
            state_q <= ARB_HOLD;
            sel_q   <= sel_s;
          end else begin
            state_q <= ARB_IDLE;
          end
        end
        ARB_HOLD: begin
          if (mem_gnt_i) begin
            state_q <= ARB_IDLE;
          end else begin
            state_q <= ARB_HOLD;
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
      if (hs_s) begin
        rr_q <= (sel_s == ARB_SRC_DATA) ? ARB_SRC_INSTR : ARB_SRC_DATA;
      end
    end
  end

  cve2_arb_id_fifo #(
    .Depth (MaxOutstanding)
  ) u_id_fifo (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .push_i     (hs_s),
    .push_src_i (sel_s),
    .pop_i      (pop_s),
    .head_o     (head_s),
    .full_o     (fifo_full_s),
    .empty_o    (fifo_empty_s)
  );

  assign pop_s             = mem_rvalid_i & ~fifo_empty_s & ~rst_i;
  assign resp_unexpected_o = mem_rvalid_i & fifo_empty_s & ~rst_i;
  assign instr_rvalid_o    = pop_s & (head_s == ARB_SRC_INSTR);
  assign data_rvalid_o     = pop_s & (head_s == ARB_SRC_DATA);
  assign instr_rdata_o     = instr_rvalid_o ? mem_rdata_i : 32'h0;
  assign instr_err_o       = instr_rvalid_o & mem_err_i;
  assign data_rdata_o      = data_rvalid_o ? mem_rdata_i : 32'h0;
  assign data_err_o        = data_rvalid_o & mem_err_i;

endmodule

// File: tb/tb_cve2_obi_arbiter.sv
// Self-checking bench for cve2_obi_arbiter: directed scenarios plus a randomized
// run against a transaction-level model (outstanding queue + last-granted source).
module tb_cve2_obi_arbiter;

  logic        clk;
  logic        rst;
  logic        instr_req;
  logic [31:0] instr_addr;
  logic        data_req;
  logic        data_we;
  logic [3:0]  data_be;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        mem_err;

  logic        r_igafter, r_ignt, r_irv, r_ierr, r_dgnt, r_drv, r_derr;
  logic [31:0] r_irdata, r_drdata, r_addr, r_wdata;
  logic        r_req, r_we, r_unexp;
  logic [3:0]  r_be;

  logic        f_ignt, f_irv, f_ierr, f_dgnt, f_drv, f_derr, f_req, f_we, f_unexp;
  logic [31:0] f_irdata, f_drdata, f_addr, f_wdata;
  logic [3:0]  f_be;

  int total = 0;
  int bad   = 0;

  cve2_obi_arbiter #(.MaxOutstanding(2), .DataPriority(1'b0)) dut_rr (
    .clk_i(clk), .rst_i(rst),
    .instr_req_i(instr_req), .instr_gnt_o(r_ignt), .instr_rvalid_o(r_irv),
    .instr_addr_i(instr_addr), .instr_rdata_o(r_irdata), .instr_err_o(r_ierr),
    .data_req_i(data_req), .data_gnt_o(r_dgnt), .data_rvalid_o(r_drv),
    .data_we_i(data_we), .data_be_i(data_be), .data_addr_i(data_addr),
    .data_wdata_i(data_wdata), .data_rdata_o(r_drdata), .data_err_o(r_derr),
    .mem_req_o(r_req), .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid),
    .mem_we_o(r_we), .mem_be_o(r_be), .mem_addr_o(r_addr), .mem_wdata_o(r_wdata),
    .mem_rdata_i(mem_rdata), .mem_err_i(mem_err), .resp_unexpected_o(r_unexp)
  );

  cve2_obi_arbiter #(.MaxOutstanding(2), .DataPriority(1'b1)) dut_fp (
    .clk_i(clk), .rst_i(rst),
    .instr_req_i(instr_req), .instr_gnt_o(f_ignt), .instr_rvalid_o(f_irv),
    .instr_addr_i(instr_addr), .instr_rdata_o(f_irdata), .instr_err_o(f_ierr),
    .data_req_i(data_req), .data_gnt_o(f_dgnt), .data_rvalid_o(f_drv),
    .data_we_i(data_we), .data_be_i(data_be), .data_addr_i(data_addr),
    .data_wdata_i(data_wdata), .data_rdata_o(f_drdata), .data_err_o(f_derr),
    .mem_req_o(f_req), .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid),
    .mem_we_o(f_we), .mem_be_o(f_be), .mem_addr_o(f_addr), .mem_wdata_o(f_wdata),
    .mem_rdata_i(mem_rdata), .mem_err_i(mem_err), .resp_unexpected_o(f_unexp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    instr_req = 1'b0; instr_addr = 32'h0;
    data_req = 1'b0; data_we = 1'b0; data_be = 4'h0; data_addr = 32'h0; data_wdata = 32'h0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0; mem_err = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] outs;
    idle_inputs();
    rst = 1'b1;
    instr_req = 1'b1; data_req = 1'b1; mem_gnt = 1'b1; mem_rvalid = 1'b1;
    instr_addr = 32'h0000_0040; data_addr = 32'h0000_0080; data_be = 4'hF;
    @(negedge clk);
    outs = {r_req, r_ignt, r_dgnt, r_irv, r_drv, r_ierr, r_derr, r_we, r_be, r_unexp,
            (r_addr != 32'h0), (r_wdata != 32'h0), (r_irdata != 32'h0), (r_drdata != 32'h0), 13'h0};
    total++;
    if (outs !== 32'h0) begin
      bad++; $display("FAIL reset_outputs got=%h exp=%h", outs, 32'h0);
    end
    next_cycle();
    rst = 1'b0;
    idle_inputs();
    @(negedge clk);
    total++;
    if ({r_req, r_unexp, r_irv, r_drv} !== 4'b0000) begin
      bad++; $display("FAIL post_reset_idle got=%b exp=%b", {r_req, r_unexp, r_irv, r_drv}, 4'b0000);
    end
    next_cycle();
  endtask

  task automatic test_single_fetch();
    apply_reset();
    instr_req = 1'b1; instr_addr = 32'h0000_0180; mem_gnt = 1'b1;
    @(negedge clk);
    total++;
    if ({r_req, r_ignt, r_dgnt, r_we, r_be, r_addr, r_wdata} !== {1'b1, 1'b1, 1'b0, 1'b0, 4'hF, 32'h0000_0180, 32'h0}) begin
      bad++; $display("FAIL single_fetch_req got=%b%b%b%b %h %h %h", r_req, r_ignt, r_dgnt, r_we, r_be, r_addr, r_wdata);
    end
    next_cycle();
    idle_inputs();
    mem_rvalid = 1'b1; mem_rdata = 32'h0000_0013;
    @(negedge clk);
    total++;
    if ({r_irv, r_irdata, r_drv, r_drdata, r_unexp, r_req} !== {1'b1, 32'h0000_0013, 1'b0, 32'h0, 1'b0, 1'b0}) begin
      bad++; $display("FAIL single_fetch_rsp got irv=%b rdata=%h drv=%b drdata=%h unexp=%b exp irv=1 rdata=00000013",
                      r_irv, r_irdata, r_drv, r_drdata, r_unexp);
    end
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_round_robin();
    logic exp_d, prev_d;
    apply_reset();
    prev_d = 1'b0;
    for (int k = 0; k < 6; k++) begin
      instr_req = 1'b1; instr_addr = 32'h0000_1000 + 32'(k * 4);
      data_req = 1'b1; data_we = 1'b1; data_be = 4'h3;
      data_addr = 32'h0000_2000 + 32'(k * 4); data_wdata = 32'hDEAD_BEE0 + 32'(k);
      mem_gnt = 1'b1; mem_rvalid = (k > 0); mem_rdata = 32'hA000_0000 + 32'(k); mem_err = (k == 3);
      exp_d = ((k % 2) == 0);
      @(negedge clk);
      total++;
      if ({r_dgnt, r_ignt} !== {exp_d, ~exp_d}) begin
        bad++; $display("FAIL rr_grant k=%0d got d=%b i=%b exp d=%b i=%b", k, r_dgnt, r_ignt, exp_d, ~exp_d);
      end
      total++;
      if ({r_addr, r_wdata, r_be, r_we} !== (exp_d ? {data_addr, data_wdata, 4'h3, 1'b1} : {instr_addr, 32'h0, 4'hF, 1'b0})) begin
        bad++; $display("FAIL rr_payload k=%0d got addr=%h wdata=%h be=%h we=%b", k, r_addr, r_wdata, r_be, r_we);
      end
      if (k > 0) begin
        total++;
        if ({r_drv, r_irv, r_drdata, r_irdata, r_derr, r_ierr} !==
            {prev_d, ~prev_d, prev_d ? mem_rdata : 32'h0, prev_d ? 32'h0 : mem_rdata,
             prev_d & (k == 3), ~prev_d & (k == 3)}) begin
          bad++; $display("FAIL rr_route k=%0d got drv=%b irv=%b derr=%b ierr=%b exp data=%b", k, r_drv, r_irv, r_derr, r_ierr, prev_d);
        end
      end
      prev_d = exp_d;
      next_cycle();
    end
    idle_inputs();
  endtask

  task automatic test_fixed_priority();
    apply_reset();
    for (int k = 0; k < 4; k++) begin
      instr_req = 1'b1; instr_addr = 32'h0000_3000;
      data_req = 1'b1; data_addr = 32'h0000_4000 + 32'(k * 4); data_be = 4'hC;
      mem_gnt = 1'b1; mem_rvalid = (k > 0); mem_rdata = 32'h5;
      @(negedge clk);
      total++;
      if ({f_dgnt, f_ignt, f_addr} !== {1'b1, 1'b0, data_addr}) begin
        bad++; $display("FAIL fixed_prio k=%0d got d=%b i=%b addr=%h exp d=1 i=0 addr=%h", k, f_dgnt, f_ignt, f_addr, data_addr);
      end
      next_cycle();
    end
    idle_inputs();
  endtask

  task automatic test_hold();
    apply_reset();
    instr_req = 1'b1; instr_addr = 32'h0000_0500; data_addr = 32'h0000_0600; data_be = 4'h1;
    for (int k = 0; k < 4; k++) begin
      data_req = (k >= 1);
      mem_gnt = (k == 3);
      @(negedge clk);
      total++;
      if ({r_req, r_addr, r_ignt, r_dgnt} !== {1'b1, 32'h0000_0500, (k == 3), 1'b0}) begin
        bad++; $display("FAIL hold k=%0d got req=%b addr=%h ignt=%b dgnt=%b exp addr=00000500", k, r_req, r_addr, r_ignt, r_dgnt);
      end
      next_cycle();
    end
    instr_req = 1'b0; mem_gnt = 1'b1;
    @(negedge clk);
    total++;
    if ({r_dgnt, r_addr, r_be} !== {1'b1, 32'h0000_0600, 4'h1}) begin
      bad++; $display("FAIL hold_then_data got dgnt=%b addr=%h be=%h exp 1 00000600 1", r_dgnt, r_addr, r_be);
    end
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_full_fifo();
    apply_reset();
    instr_req = 1'b1; mem_gnt = 1'b1;
    for (int k = 0; k < 5; k++) begin
      instr_addr = 32'h0000_0700 + 32'(k * 4);
      mem_rvalid = (k == 3); mem_rdata = 32'h77;
      @(negedge clk);
      total++;
      if ({r_req, r_ignt, r_irv} !== {(k != 2 && k != 3), (k != 2 && k != 3), (k == 3)}) begin
        bad++; $display("FAIL full_fifo k=%0d got req=%b gnt=%b irv=%b", k, r_req, r_ignt, r_irv);
      end
      next_cycle();
    end
    idle_inputs();
  endtask

  task automatic test_reset_stray();
    apply_reset();
    instr_req = 1'b1; mem_gnt = 1'b1; instr_addr = 32'h0000_0900;
    next_cycle();
    next_cycle();
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    total++;
    if ({r_req, r_irv, r_drv, r_unexp} !== 4'b0000) begin
      bad++; $display("FAIL reset_mid_op got=%b exp=0000", {r_req, r_irv, r_drv, r_unexp});
    end
    next_cycle();
    rst = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      total++;
      if ({r_unexp, r_irv, r_drv, r_irdata, r_drdata} !== {1'b1, 1'b0, 1'b0, 32'h0, 32'h0}) begin
        bad++; $display("FAIL stray_resp k=%0d got unexp=%b irv=%b drv=%b exp unexp=1 irv=0 drv=0", k, r_unexp, r_irv, r_drv);
      end
      next_cycle();
    end
    idle_inputs();
  endtask

  task automatic test_random();
    int          outstanding[$];
    int          pending;
    int          last_granted;
    logic        e_req, e_sel, e_ig, e_dg, e_irv, e_drv, e_unexp;
    logic [72:0] exp_bus, got_bus;
    logic [70:0] exp_rsp, got_rsp;
    apply_reset();
    pending = -1;
    last_granted = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      instr_req  = ($urandom_range(0, 1) == 1) || (pending == 0);
      data_req   = ($urandom_range(0, 1) == 1) || (pending == 1);
      instr_addr = $urandom;
      data_addr  = $urandom;
      data_wdata = $urandom;
      data_we    = $urandom_range(0, 1) == 1;
      data_be    = 4'($urandom_range(0, 15));
      mem_gnt    = $urandom_range(0, 3) != 0;
      mem_rvalid = $urandom_range(0, 1) == 1;
      mem_rdata  = $urandom;
      mem_err    = $urandom_range(0, 3) == 0;

      e_req = 1'b0; e_sel = 1'b0;
      if (pending >= 0) begin
        e_req = 1'b1; e_sel = (pending == 1);
      end else if (outstanding.size() < 2 && (instr_req || data_req)) begin
        e_req = 1'b1;
        e_sel = (instr_req && data_req) ? (last_granted == 0) : data_req;
      end
      e_ig = e_req && mem_gnt && !e_sel;
      e_dg = e_req && mem_gnt && e_sel;
      exp_bus = {e_req, e_ig, e_dg,
                 e_req && e_sel && data_we,
                 !e_req ? 4'h0 : (e_sel ? data_be : 4'hF),
                 !e_req ? 32'h0 : (e_sel ? data_addr : instr_addr),
                 (e_req && e_sel) ? data_wdata : 32'h0};

      e_irv = 1'b0; e_drv = 1'b0; e_unexp = 1'b0;
      if (mem_rvalid && outstanding.size() > 0) begin
        e_irv = (outstanding[0] == 0);
        e_drv = (outstanding[0] == 1);
      end else if (mem_rvalid) begin
        e_unexp = 1'b1;
      end
      exp_rsp = {e_irv, e_irv ? mem_rdata : 32'h0, e_irv & mem_err,
                 e_drv, e_drv ? mem_rdata : 32'h0, e_drv & mem_err, e_unexp};

      @(negedge clk);
      got_bus = {r_req, r_ignt, r_dgnt, r_we, r_be, r_addr, r_wdata};
      got_rsp = {r_irv, r_irdata, r_ierr, r_drv, r_drdata, r_derr, r_unexp};
      total++;
      if (got_bus !== exp_bus) begin
        bad++; $display("FAIL rand_request cyc=%0d got=%h exp=%h", cyc, got_bus, exp_bus);
      end
      total++;
      if (got_rsp !== exp_rsp) begin
        bad++; $display("FAIL rand_response cyc=%0d got=%h exp=%h", cyc, got_rsp, exp_rsp);
      end

      if (mem_rvalid && outstanding.size() > 0) void'(outstanding.pop_front());
      if (e_req && mem_gnt) begin
        outstanding.push_back(int'(e_sel));
        last_granted = int'(e_sel);
        pending = -1;
      end else if (e_req) begin
        pending = int'(e_sel);
      end
      next_cycle();
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    next_cycle();
    test_reset();
    test_single_fetch();
    test_round_robin();
    test_fixed_priority();
    test_hold();
    test_full_fifo();
    test_reset_stray();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
